// File: rtl/ama_riscv_fetch.sv
// ama_riscv_fetch
// Instruction fetch stage: owns the fetch PC, issues in-order IMEM reads over
// a valid/ready handshake, buffers returned instructions with their PCs in a
// QDEPTH-entry in-order queue and squashes in-flight fetches on redirect.
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined     - a response filling the pending head entry is presented to
//                 decode combinationally in the same cycle
//   not defined - responses are registered into the queue first (+1 cycle)
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   redir, pc_sel       redirect strobe and source (INC4/ALU/BP/PC)
//   alu_tgt, bp_tgt     redirect targets (low 2 bits ignored)
//   imem_req_*          request channel (valid/ready, word-aligned address)
//   imem_rsp_*          in-order response channel
//   dec_valid/inst/pc   head instruction to decode, dec_ready pops it
module ama_riscv_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0004_0000,
  parameter int unsigned QDEPTH       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redir,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] alu_tgt,
  input  logic [31:0] bp_tgt,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_SEL_INC4 = 2'd0,
    PC_SEL_ALU  = 2'd1,
    PC_SEL_BP   = 2'd2,
    PC_SEL_PC   = 2'd3
  } pc_sel_t;

  typedef enum logic [1:0] {
    RST  = 2'd0,
    BOOT = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc;
  logic [31:0]   q_pc   [QDEPTH];
  logic [31:0]   q_inst [QDEPTH];
  logic [PW-1:0] head, tail, fill_ptr;
  // Entries [head, head+fill_cnt) are filled, the rest of alloc_cnt pending;
  // responses return in order so filled entries always form a prefix.
  logic [CW-1:0] alloc_cnt, fill_cnt, pending;
  logic [7:0]    drop_cnt;

  logic          redir_eff;
  logic [31:0]   redir_tgt;
  logic          run, req_fire, pop, rsp_drop, rsp_fill, head_byp;

  // FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RST:     state_d = BOOT;
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = RST;
    endcase
  end

  assign run = (state_q == RUN);

  // Redirect decode; INC4 means the strobe has no effect at all
  always_comb begin
    redir_eff = 1'b0;
    redir_tgt = fetch_pc;
    if (redir) begin
      case (pc_sel_t'(pc_sel))
        PC_SEL_ALU: begin redir_eff = 1'b1; redir_tgt = alu_tgt & 32'hFFFF_FFFC; end
        PC_SEL_BP:  begin redir_eff = 1'b1; redir_tgt = bp_tgt & 32'hFFFF_FFFC; end
        PC_SEL_PC:  begin redir_eff = 1'b1; redir_tgt = RESET_VECTOR & 32'hFFFF_FFFC; end
        default:    begin redir_eff = 1'b0; redir_tgt = fetch_pc; end
      endcase
    end
  end

  assign pending  = alloc_cnt - fill_cnt;
  assign fill_ptr = head + fill_cnt[PW-1:0];
  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid && (drop_cnt == '0) && (pending != '0);

`ifdef FETCH_BYPASS_EN
  assign head_byp = rsp_fill && (fill_cnt == '0);
`else
  assign head_byp = 1'b0;
`endif

  always_comb begin
    imem_req_valid = run && (alloc_cnt != CW'(QDEPTH)) && !redir_eff;
    imem_req_addr  = fetch_pc;
    dec_valid      = (fill_cnt != '0) || head_byp;
    dec_inst       = NOP;
    dec_pc         = '0;
    if (dec_valid) begin
      dec_inst = head_byp ? imem_rsp_data : q_inst[head];
      dec_pc   = q_pc[head];
    end
  end

  assign req_fire = imem_req_valid && imem_req_ready;
  // A redirect wins over decode consumption of the head in the same cycle
  assign pop      = dec_valid && dec_ready && !redir_eff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_VECTOR;
      head      <= '0;
      tail      <= '0;
      alloc_cnt <= '0;
      fill_cnt  <= '0;
      drop_cnt  <= '0;
    end else if (redir_eff) begin
      fetch_pc  <= redir_tgt;
      head      <= '0;
      tail      <= '0;
      alloc_cnt <= '0;
      fill_cnt  <= '0;
      // Everything still in flight becomes stale, minus the response that
      // is being consumed (dropped or discarded fill) this very cycle.
      drop_cnt  <= drop_cnt + 8'(pending) - 8'(rsp_drop || rsp_fill);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
        tail     <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      alloc_cnt <= alloc_cnt + CW'(req_fire) - CW'(pop);
      fill_cnt  <= fill_cnt + CW'(rsp_fill) - CW'(pop);
      if (rsp_drop) drop_cnt <= drop_cnt - 8'd1;
    end
  end

  // Queue storage needs no reset: outputs are masked while dec_valid is low
  always_ff @(posedge clk) begin
    if (rst_n && req_fire) q_pc[tail] <= fetch_pc;
    if (rsp_fill)          q_inst[fill_ptr] <= imem_rsp_data;
  end

  // A response with nothing pending and nothing to drop is a protocol error
  always_ff @(posedge clk) begin
    if (rst_n && imem_rsp_valid) begin
      assert (rsp_drop || rsp_fill);
    end
  end

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Testbench for ama_riscv_fetch: directed stimulus, transaction-level model
// (expected decode stream = accepted, non-squashed request PCs in order) with
// per-cycle checking, plus literal expectations for key events.
module tb_ama_riscv_fetch;

  localparam logic [31:0] RV     = 32'h0004_0000;
  localparam int          QDEPTH = 2;
`ifdef FETCH_BYPASS_EN
  localparam int EXTRA = 0;
`else
  localparam int EXTRA = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redir = 1'b0;
  logic [1:0]  pc_sel = 2'd0;
  logic [31:0] alu_tgt = '0;
  logic [31:0] bp_tgt = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_ready = 1'b0;

  ama_riscv_fetch #(.RESET_VECTOR(RV), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .redir(redir), .pc_sel(pc_sel),
    .alu_tgt(alu_tgt), .bp_tgt(bp_tgt),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .dec_valid(dec_valid), .dec_inst(dec_inst),
    .dec_pc(dec_pc), .dec_ready(dec_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct { logic [31:0] pc; bit filled; } ent_t;
  typedef struct { logic [31:0] addr; bit live; } mem_t;
  typedef struct { int cyc; logic [31:0] v; } ev_t;

  ent_t exp_q[$];
  mem_t imem_q[$];
  ev_t  acc_log[$];
  ev_t  pop_log[$];
  logic [31:0] m_pc = RV;
  int   since = 0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
  endtask

  // One clock cycle: drive inputs, check outputs against model, advance model
  task automatic step(input bit rn, input bit rd, input logic [1:0] sel,
                      input bit rqr, input bit dr, input bit ren);
    bit eff, run, exp_rv, exp_dv, rsp_live, fire, pop;
    logic [31:0] tgt;
    mem_t r;
    @(negedge clk);
    cyc++;
    rst_n = rn; redir = rd; pc_sel = sel; imem_req_ready = rqr; dec_ready = dr;
    if (ren && imem_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(imem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    eff = rd && (sel != 2'd0);
    tgt = (sel == 2'd1) ? alu_tgt : (sel == 2'd2) ? bp_tgt : RV;
    run = (since >= 2);
    exp_rv = run && (exp_q.size() < QDEPTH) && !eff;
    rsp_live = imem_rsp_valid && imem_q[0].live;
    exp_dv = (exp_q.size() > 0) && (exp_q[0].filled || (EXTRA == 0 && rsp_live));
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
    chk("dec_valid", 32'(dec_valid), 32'(exp_dv));
    if (exp_dv) begin
      chk("dec_pc", dec_pc, exp_q[0].pc);
      chk("dec_inst", dec_inst, inst_of(exp_q[0].pc));
    end
    fire = exp_rv && rqr;
    pop  = exp_dv && dr && !eff;
    @(posedge clk);
    if (!rn) begin
      since = 0; m_pc = RV;
      exp_q.delete(); imem_q.delete();
    end else begin
      if (since < 2) since++;
      if (imem_rsp_valid) begin
        r = imem_q.pop_front();
        if (r.live && !eff) begin
          for (int i = 0; i < exp_q.size(); i++)
            if (!exp_q[i].filled) begin exp_q[i].filled = 1'b1; break; end
        end
      end
      if (eff) begin
        exp_q.delete();
        foreach (imem_q[i]) imem_q[i].live = 1'b0;
        m_pc = tgt & 32'hFFFF_FFFC;
      end else begin
        if (pop) begin
          pop_log.push_back('{cyc, exp_q[0].pc});
          void'(exp_q.pop_front());
        end
        if (fire) begin
          acc_log.push_back('{cyc, m_pc});
          exp_q.push_back('{m_pc, 1'b0});
          imem_q.push_back('{m_pc, 1'b1});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 2'd0, 1, 1, 1);
  endtask

  // First logged event strictly after cycle 'after'; -1 / DEADBEEF if none
  task automatic first_after(input bit is_pop, input int after,
                             output int c, output logic [31:0] v);
    c = -1; v = 32'hDEAD_BEEF;
    if (is_pop) begin
      foreach (pop_log[i]) if (pop_log[i].cyc > after) begin
        c = pop_log[i].cyc; v = pop_log[i].v; break;
      end
    end else begin
      foreach (acc_log[i]) if (acc_log[i].cyc > after) begin
        c = acc_log[i].cyc; v = acc_log[i].v; break;
      end
    end
  endtask

  task automatic reset_pins();
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0004_0000);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_inst", dec_inst, 32'h0000_0013);
    chk("rst_dec_pc", dec_pc, 32'h0000_0000);
  endtask

  initial begin
    int c0, c, c2, rc, bad;
    logic [31:0] v, v2;
    logic [15:0] pat;
    pat = 16'b1011_0010_1110_0101;

    // Reset and boot
    repeat (3) step(0, 0, 2'd0, 1, 1, 1);
    reset_pins();
    step(1, 0, 2'd0, 1, 1, 1);
    c0 = cyc;
    run_n(12);
    first_after(0, c0 - 1, c, v);
    chk("first_req_cyc", 32'(c), 32'(c0 + 2));
    chk("first_req_addr", v, 32'h0004_0000);
    first_after(0, c, c2, v2);
    chk("second_req_cyc", 32'(c2), 32'(c0 + 3));
    chk("second_req_addr", v2, 32'h0004_0004);
    first_after(1, c0 - 1, c, v);
    chk("first_dec_cyc", 32'(c), 32'(c0 + 3 + EXTRA));
    chk("first_dec_pc", v, 32'h0004_0000);

    // Decode stall: queue fills, request drops, outputs hold; then drain
    repeat (5) step(1, 0, 2'd0, 1, 0, 1);
    run_n(8);

    // ALU redirect with two pending entries (responses held back)
    repeat (4) step(1, 0, 2'd0, 1, 1, 0);
    alu_tgt = 32'h0004_0103;
    step(1, 1, 2'd1, 1, 1, 0);
    rc = cyc;
    run_n(10);
    first_after(0, rc, c, v);
    chk("alu_req_cyc", 32'(c), 32'(rc + 1));
    chk("alu_req_addr", v, 32'h0004_0100);
    first_after(1, rc, c, v);
    chk("alu_first_dec_pc", v, 32'h0004_0100);

    // INC4 strobe: no effect on the stream
    step(1, 1, 2'd0, 1, 1, 1);
    rc = cyc;
    run_n(6);
    v2 = 32'hDEAD_BEEF;
    foreach (pop_log[i]) if (pop_log[i].cyc <= rc) v2 = pop_log[i].v;
    first_after(1, rc, c, v);
    chk("inc4_contiguous", v, v2 + 32'd4);

    // BP redirect while decode is ready
    bp_tgt = 32'h0005_0200;
    step(1, 1, 2'd2, 1, 1, 1);
    rc = cyc;
    run_n(8);
    first_after(1, rc, c, v);
    chk("bp_first_dec_pc", v, 32'h0005_0200);

    // Request backpressure pattern
    for (int i = 0; i < 16; i++) step(1, 0, 2'd0, pat[i], 1, 1);
    run_n(4);

    // 32-bit PC wrap
    alu_tgt = 32'hFFFF_FFF8;
    step(1, 1, 2'd1, 1, 1, 1);
    rc = cyc;
    run_n(10);
    c = -1; v = 32'hDEAD_BEEF;
    foreach (pop_log[i])
      if (c < 0 && pop_log[i].cyc > rc && pop_log[i].v == 32'hFFFF_FFFC) c = i;
    if (c >= 0 && c + 1 < pop_log.size()) v = pop_log[c + 1].v;
    chk("wrap_pc", v, 32'h0000_0000);

    // Redirect to reset vector
    step(1, 1, 2'd3, 1, 1, 1);
    rc = cyc;
    run_n(6);
    first_after(0, rc, c, v);
    chk("pcsel_pc_addr", v, 32'h0004_0000);

    // Whole-run contiguity between redirects is covered by the model; spot
    // check that the final segment has no skipped or duplicated PC.
    bad = 0;
    foreach (pop_log[i])
      if (i > 0 && pop_log[i].cyc > rc && pop_log[i-1].cyc > rc &&
          pop_log[i].v != pop_log[i-1].v + 32'd4) bad++;
    chk("tail_contiguous", 32'(bad), 32'd0);

    // Mid-stream reset for one cycle
    step(0, 0, 2'd0, 1, 1, 1);
    reset_pins();
    step(1, 0, 2'd0, 1, 1, 1);
    c0 = cyc;
    run_n(8);
    first_after(0, c0 - 1, c, v);
    chk("rerst_req_cyc", 32'(c), 32'(c0 + 2));
    chk("rerst_req_addr", v, 32'h0004_0000);
    first_after(1, c0 - 1, c, v);
    chk("rerst_dec_cyc", 32'(c), 32'(c0 + 3 + EXTRA));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
